// File: rtl/pxs_pkg.sv
// Shared definitions for the sprite controller: stream layout, object record, FSM states.
package pxs_pkg;

    localparam int unsigned STREAM_W = 26;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned RGB_W    = 3;

    localparam int unsigned RGB_HI = 25;
    localparam int unsigned RGB_LO = 23;
    localparam int unsigned X_HI   = 22;
    localparam int unsigned X_LO   = 13;
    localparam int unsigned Y_HI   = 12;
    localparam int unsigned Y_LO   = 3;
    localparam int unsigned HS_BIT = 2;
    localparam int unsigned VS_BIT = 1;
    localparam int unsigned AV_BIT = 0;

    localparam logic [RGB_W-1:0] BLACK = '0;
    localparam logic [RGB_W-1:0] WHITE = '1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [RGB_W-1:0]   rgb;
        logic               en;
    } obj_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/pxs_obj_hit.sv
// Single-slot rectangle hit test; 11-bit end compare so x+w past 1023 never wraps.
module pxs_obj_hit
    import pxs_pkg::*;
(
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_w,
    input  logic [COORD_W-1:0] obj_h,
    input  logic               obj_en,
    input  logic [COORD_W-1:0] px_x,
    input  logic [COORD_W-1:0] px_y,
    input  logic               av,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, obj_x} + {1'b0, obj_w};
    assign y_end = {1'b0, obj_y} + {1'b0, obj_h};

    assign hit = obj_en & av
               & (px_x >= obj_x) & ({1'b0, px_x} < x_end)
               & (px_y >= obj_y) & ({1'b0, px_y} < y_end);

endmodule

// File: rtl/pxs_sprite_ctrl.sv
// Sprite overlay on the VGA stream with tear-free shadow->active swap at VSync.
// Optional collision flags: define PXS_SPRITE_COLLISION_EN.
module pxs_sprite_ctrl
    import pxs_pkg::*;
#(
    parameter int unsigned NUM_OBJ   = 4,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic                px_clk,
    input  logic                rst_n,
    input  logic [STREAM_W-1:0] VGA_SCA_RGB_Str_i,
    output logic [STREAM_W-1:0] VGA_SCA_RGB_Str_o,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_idx,
    input  logic [COORD_W-1:0]  cfg_x,
    input  logic [COORD_W-1:0]  cfg_y,
    input  logic [COORD_W-1:0]  cfg_w,
    input  logic [COORD_W-1:0]  cfg_h,
    input  logic [RGB_W-1:0]    cfg_rgb,
    input  logic                cfg_en,
    input  logic                cfg_commit,
    output logic                commit_busy,
    output logic [15:0]         frame_cnt
`ifdef PXS_SPRITE_COLLISION_EN
    ,
    output logic [NUM_OBJ-1:0]  coll_flags
`endif
);

    state_t              state, state_d;
    obj_t                shadow [NUM_OBJ];
    obj_t                active [NUM_OBJ];
    obj_t                wr_obj;
    logic                vs_hist;
    logic                boundary;
    logic                wr_en;
    logic [NUM_OBJ-1:0]  hit_d, hit_s1;
    logic [STREAM_W-1:0] str_s1;
    logic                sel_hit;
    logic [RGB_W-1:0]    sel_rgb;

    assign boundary = (VGA_SCA_RGB_Str_i[VS_BIT] == VSYNC_POL) && (vs_hist != VSYNC_POL);
    assign wr_en    = cfg_valid && cfg_ready && (32'(cfg_idx) < NUM_OBJ);
    assign wr_obj   = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, rgb: cfg_rgb, en: cfg_en};

    always_comb begin
        state_d     = state;
        cfg_ready   = 1'b0;
        commit_busy = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_commit) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                commit_busy = 1'b1;
                if (boundary) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_busy = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vs_hist   <= ~VSYNC_POL;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state   <= state_d;
            vs_hist <= VGA_SCA_RGB_Str_i[VS_BIT];
            if (boundary) frame_cnt <= frame_cnt + 16'd1;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                if (wr_en && cfg_idx == 3'(i)) shadow[i] <= wr_obj;
                // Slots written in the commit-accept cycle are already in shadow here.
                if (state == ST_COMMIT) active[i] <= shadow[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        pxs_obj_hit u_hit (
            .obj_x  (active[g].x),
            .obj_y  (active[g].y),
            .obj_w  (active[g].w),
            .obj_h  (active[g].h),
            .obj_en (active[g].en),
            .px_x   (VGA_SCA_RGB_Str_i[X_HI:X_LO]),
            .px_y   (VGA_SCA_RGB_Str_i[Y_HI:Y_LO]),
            .av     (VGA_SCA_RGB_Str_i[AV_BIT]),
            .hit    (hit_d[g])
        );
    end

    always_comb begin
        sel_hit = 1'b0;
        sel_rgb = str_s1[RGB_HI:RGB_LO];
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (hit_s1[i] && !sel_hit) begin
                sel_hit = 1'b1;
                sel_rgb = active[i].rgb;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            str_s1            <= '0;
            hit_s1            <= '0;
            VGA_SCA_RGB_Str_o <= '0;
        end else begin
            str_s1            <= VGA_SCA_RGB_Str_i;
            hit_s1            <= hit_d;
            VGA_SCA_RGB_Str_o <= {sel_rgb, str_s1[X_HI:0]};
        end
    end

`ifdef PXS_SPRITE_COLLISION_EN
    logic [NUM_OBJ-1:0] coll_now, coll_acc;

    always_comb begin
        coll_now = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++)
            for (int unsigned j = 0; j < NUM_OBJ; j++)
                if (i != j && hit_s1[i] && hit_s1[j]) coll_now[i] = 1'b1;
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_acc   <= '0;
            coll_flags <= '0;
        end else if (boundary) begin
            coll_flags <= coll_acc | coll_now;
            coll_acc   <= '0;
        end else begin
            coll_acc <= coll_acc | coll_now;
        end
    end
`endif

endmodule

// File: tb/tb_pxs_sprite_ctrl.sv
// Directed bench for pxs_sprite_ctrl: drive on negedge, sample on negedge.
module tb_pxs_sprite_ctrl;

    localparam logic [2:0] BG = 3'b011;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic [25:0] str_i, str_o;
    logic        cfg_valid, cfg_ready, cfg_en, cfg_commit, commit_busy;
    logic [2:0]  cfg_idx, cfg_rgb;
    logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h;
    logic [15:0] frame_cnt;
    logic [3:0]  coll_flags;

    int n_checks = 0;
    int n_errors = 0;
    int exp_frames = 0;

    always #5 px_clk = ~px_clk;

    pxs_sprite_ctrl #(.NUM_OBJ(4), .VSYNC_POL(1'b0)) dut (
        .px_clk            (px_clk),
        .rst_n             (rst_n),
        .VGA_SCA_RGB_Str_i (str_i),
        .VGA_SCA_RGB_Str_o (str_o),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_idx           (cfg_idx),
        .cfg_x             (cfg_x),
        .cfg_y             (cfg_y),
        .cfg_w             (cfg_w),
        .cfg_h             (cfg_h),
        .cfg_rgb           (cfg_rgb),
        .cfg_en            (cfg_en),
        .cfg_commit        (cfg_commit),
        .commit_busy       (commit_busy),
        .frame_cnt         (frame_cnt)
`ifdef PXS_SPRITE_COLLISION_EN
        ,
        .coll_flags        (coll_flags)
`endif
    );

`ifndef PXS_SPRITE_COLLISION_EN
    assign coll_flags = '0;
`endif

    function automatic logic [25:0] mk(input logic [2:0] rgb, input logic [9:0] x, input logic [9:0] y,
                                       input logic vs, input logic av);
        return {rgb, x, y, 1'b1, vs, av};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] w, input logic [9:0] h, input logic [2:0] rgb,
                      input logic en, input logic commit);
        @(negedge px_clk);
        cfg_valid = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
        cfg_rgb = rgb; cfg_en = en; cfg_commit = commit;
        @(negedge px_clk);
        cfg_valid = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic commit();
        @(negedge px_clk);
        check("commit_ready", 32'(cfg_ready), 32'd1);
        cfg_commit = 1'b1;
        @(negedge px_clk);
        cfg_commit = 1'b0;
        check("pend_busy", 32'(commit_busy), 32'd1);
        check("pend_ready", 32'(cfg_ready), 32'd0);
    endtask

    task automatic do_vsync();
        @(negedge px_clk);
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b0, 1'b0);
        exp_frames++;
        repeat (2) @(negedge px_clk);
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b1, 1'b0);
        repeat (2) @(negedge px_clk);
    endtask

    // pixel held for one cycle, checked exactly two cycles later
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic av, input logic [2:0] exp_rgb);
        @(negedge px_clk);
        str_i = mk(BG, x, y, 1'b1, av);
        @(negedge px_clk);
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b1, 1'b0);
        @(negedge px_clk);
        check(tag, 32'(str_o), 32'(mk(exp_rgb, x, y, 1'b1, av)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_idx = '0;
        cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_rgb = '0; cfg_en = 1'b0;
        str_i = mk(BG, 10'd100, 10'd50, 1'b1, 1'b1);
        repeat (3) @(negedge px_clk);
        check("rst_out", 32'(str_o), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(commit_busy), 32'd0);
        check("rst_frames", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b1, 1'b0);

        // load and draw
        wr(3'd0, 10'd100, 10'd50, 10'd8, 10'd8, 3'b100, 1'b1, 1'b0);
        commit();
        pix("pre_commit_bg", 10'd100, 10'd50, 1'b1, BG);
        do_vsync();
        check("post_busy", 32'(commit_busy), 32'd0);
        pix("draw_tl", 10'd100, 10'd50, 1'b1, 3'b100);
        pix("draw_br", 10'd107, 10'd57, 1'b1, 3'b100);
        pix("right_edge", 10'd108, 10'd50, 1'b1, BG);
        pix("left_edge", 10'd99, 10'd50, 1'b1, BG);
        pix("bottom_edge", 10'd100, 10'd58, 1'b1, BG);
        pix("av_low", 10'd100, 10'd50, 1'b0, BG);

        // priority
        wr(3'd0, 10'd196, 10'd196, 10'd8, 10'd8, 3'b001, 1'b1, 1'b0);
        wr(3'd1, 10'd200, 10'd200, 10'd10, 10'd10, 3'b010, 1'b1, 1'b0);
        commit();
        do_vsync();
        pix("prio_overlap", 10'd200, 10'd200, 1'b1, 3'b001);
        pix("prio_slot1", 10'd205, 10'd205, 1'b1, 3'b010);
        pix("prio_outside", 10'd195, 10'd200, 1'b1, BG);

        // write + commit in one cycle: the disable of slot 1 must be included
        wr(3'd0, 10'd100, 10'd50, 10'd8, 10'd8, 3'b100, 1'b1, 1'b0);
        wr(3'd1, 10'd200, 10'd200, 10'd10, 10'd10, 3'b010, 1'b0, 1'b1);
        check("wc_busy", 32'(commit_busy), 32'd1);
        do_vsync();
        pix("wc_slot1_off", 10'd205, 10'd205, 1'b1, BG);
        pix("wc_slot0", 10'd100, 10'd50, 1'b1, 3'b100);

        // tear-free move
        wr(3'd0, 10'd300, 10'd50, 10'd8, 10'd8, 3'b100, 1'b1, 1'b0);
        commit();
        pix("tear_old", 10'd100, 10'd50, 1'b1, 3'b100);
        pix("tear_new_bg", 10'd300, 10'd50, 1'b1, BG);
        check("tear_ready", 32'(cfg_ready), 32'd0);
        do_vsync();
        pix("moved_new", 10'd300, 10'd50, 1'b1, 3'b100);
        pix("moved_old_bg", 10'd100, 10'd50, 1'b1, BG);

        // edges; commit accepted in the same cycle as a boundary
        wr(3'd2, 10'd1020, 10'd10, 10'd10, 10'd1, 3'b110, 1'b1, 1'b0);
        wr(3'd3, 10'd500, 10'd10, 10'd0, 10'd5, 3'b111, 1'b1, 1'b0);
        wr(3'd5, 10'd0, 10'd10, 10'd1023, 10'd5, 3'b101, 1'b1, 1'b0);
        @(negedge px_clk);
        cfg_commit = 1'b1;
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b0, 1'b0);
        exp_frames++;
        @(negedge px_clk);
        cfg_commit = 1'b0;
        @(negedge px_clk);
        str_i = mk(3'b000, 10'd0, 10'd0, 1'b1, 1'b0);
        repeat (2) @(negedge px_clk);
        check("same_cycle_bnd_busy", 32'(commit_busy), 32'd1);
        pix("same_cycle_not_swapped", 10'd1020, 10'd10, 1'b1, BG);
        do_vsync();
        pix("edge_1020", 10'd1020, 10'd10, 1'b1, 3'b110);
        pix("edge_1023", 10'd1023, 10'd10, 1'b1, 3'b110);
        pix("edge_1019", 10'd1019, 10'd10, 1'b1, BG);
        pix("edge_nowrap0", 10'd0, 10'd10, 1'b1, BG);
        pix("edge_nowrap3", 10'd3, 10'd10, 1'b1, BG);
        pix("edge_h1", 10'd1020, 10'd11, 1'b1, BG);
        pix("w0_nohit", 10'd500, 10'd10, 1'b1, BG);

        // collision
        wr(3'd2, 10'd600, 10'd300, 10'd10, 10'd10, 3'b110, 1'b1, 1'b0);
        wr(3'd3, 10'd605, 10'd300, 10'd10, 10'd10, 3'b111, 1'b1, 1'b0);
        commit();
        do_vsync();
        pix("coll_pix_both", 10'd607, 10'd302, 1'b1, 3'b110);
        pix("coll_pix_s3", 10'd612, 10'd302, 1'b1, 3'b111);
        wr(3'd3, 10'd700, 10'd300, 10'd10, 10'd10, 3'b111, 1'b1, 1'b0);
        commit();
        do_vsync();
`ifdef PXS_SPRITE_COLLISION_EN
        check("coll_flags_set", 32'(coll_flags), 32'h0000000c);
`endif
        pix("sep_pix", 10'd607, 10'd302, 1'b1, 3'b110);
        do_vsync();
`ifdef PXS_SPRITE_COLLISION_EN
        check("coll_flags_clr", 32'(coll_flags), 32'h00000000);
`endif
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // reset while a commit is pending
        wr(3'd0, 10'd400, 10'd60, 10'd8, 10'd8, 3'b100, 1'b1, 1'b0);
        commit();
        @(negedge px_clk);
        rst_n = 1'b0;
        @(negedge px_clk);
        check("rst2_busy", 32'(commit_busy), 32'd0);
        check("rst2_ready", 32'(cfg_ready), 32'd1);
        check("rst2_frames", 32'(frame_cnt), 32'd0);
        check("rst2_out", 32'(str_o), 32'd0);
        rst_n = 1'b1;
        exp_frames = 0;
        do_vsync();
        check("rst2_no_commit", 32'(commit_busy), 32'd0);
        check("rst2_frame1", 32'(frame_cnt), 32'(exp_frames));
        pix("rst2_cleared", 10'd300, 10'd50, 1'b1, BG);
        pix("rst2_discarded", 10'd400, 10'd60, 1'b1, BG);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
